// File: rtl/gpio_pkg.sv
// Shared types and register-window layout for the GPIO output controller.
package gpio_pkg;

  localparam logic [4:0] STR_UOP = 5'd9;

  localparam int unsigned OFF_DIRECT = 0;
  localparam int unsigned OFF_SET    = 4;
  localparam int unsigned OFF_CLR    = 8;
  localparam int unsigned OFF_TOG    = 12;
  localparam int unsigned OFF_PERIOD = 16;
  localparam int unsigned OFF_CTRL   = 20;
  localparam int unsigned OFF_PAT0   = 24;

  localparam int unsigned NUM_REGS   = 10;

  localparam int unsigned SEL_DIRECT = OFF_DIRECT / 4;
  localparam int unsigned SEL_SET    = OFF_SET / 4;
  localparam int unsigned SEL_CLR    = OFF_CLR / 4;
  localparam int unsigned SEL_TOG    = OFF_TOG / 4;
  localparam int unsigned SEL_PERIOD = OFF_PERIOD / 4;
  localparam int unsigned SEL_CTRL   = OFF_CTRL / 4;
  localparam int unsigned SEL_PAT0   = OFF_PAT0 / 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } seq_state_t;

  typedef struct packed {
    logic oneshot;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/gpio_decode.sv
// Combinational store decoder: qualifies a store into the control window
// and produces a one-hot register select.
module gpio_decode
  import gpio_pkg::*;
#(
  parameter logic [4:0]  UOP_CODE = 5'd9,
  parameter logic [31:0] BASE     = 32'd32
) (
  input  logic [4:0]          i_uop,
  input  logic [31:0]         i_addr,
  output logic                o_valid,
  output logic [NUM_REGS-1:0] o_sel
);

  logic [3:0] w_idx;

  always_comb begin
    // Base is word-aligned, so the word index only needs the low address bits.
    w_idx   = i_addr[5:2] - BASE[5:2];
    o_valid = (i_uop == UOP_CODE) && (i_addr[1:0] == 2'b00) &&
              (i_addr >= BASE) && (i_addr <= BASE + 32'd36);
    o_sel   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      o_sel[i] = o_valid && (w_idx == i[3:0]);
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO output register owner: CPU store updates plus an autonomous
// pattern sequencer; CPU stores take priority over sequencer loads.
module gpio_ctrl #(
  parameter logic [4:0]  STR_UOP   = 5'd9,
  parameter logic [31:0] BASE_ADDR = 32'd32,
  parameter int unsigned NUM_PAT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  uop,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] state,
  output logic        seq_busy,
  output logic [1:0]  seq_idx,
  output logic        wr_ack
);
  import gpio_pkg::*;

  seq_state_t          r_fsm, w_fsm_nxt;
  logic [31:0]         r_state, w_state_nxt;
  logic [23:0]         r_period;
  logic [23:0]         r_cnt, w_cnt_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  ctrl_t               r_ctrl, w_ctrl_nxt;
  logic [31:0]         r_pat [NUM_PAT];
  logic                r_wr_ack;

  logic                w_valid;
  logic [NUM_REGS-1:0] w_sel;
  logic                w_cpu_state;

  gpio_decode #(
    .UOP_CODE (STR_UOP),
    .BASE     (BASE_ADDR)
  ) u_decode (
    .i_uop   (uop),
    .i_addr  (addr),
    .o_valid (w_valid),
    .o_sel   (w_sel)
  );

  always_comb begin
    w_cpu_state = w_sel[SEL_DIRECT] | w_sel[SEL_SET] | w_sel[SEL_CLR] | w_sel[SEL_TOG];
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_ctrl_nxt  = r_ctrl;

    if (w_sel[SEL_CTRL]) begin
      w_ctrl_nxt = ctrl_t'(data_in[1:0]);
      if (data_in[0]) begin
        w_fsm_nxt = LOAD;
        w_idx_nxt = '0;
      end else begin
        w_fsm_nxt = IDLE;
      end
    end else begin
      case (r_fsm)
        LOAD: begin
          // A coincident CPU write to the output stalls the load in place.
          if (!w_cpu_state) begin
            w_state_nxt = r_pat[r_idx];
            w_cnt_nxt   = (r_period == '0) ? '0 : r_period - 24'd1;
            w_fsm_nxt   = WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            if (r_idx == 2'd3 && r_ctrl.oneshot) begin
              w_fsm_nxt     = IDLE;
              w_ctrl_nxt.en = 1'b0;
            end else begin
              w_idx_nxt = r_idx + 2'd1;
              w_fsm_nxt = LOAD;
            end
          end else begin
            w_cnt_nxt = r_cnt - 24'd1;
          end
        end
        default: ;
      endcase
    end

    if (w_sel[SEL_DIRECT])   w_state_nxt = data_in;
    else if (w_sel[SEL_SET]) w_state_nxt = r_state | data_in;
    else if (w_sel[SEL_CLR]) w_state_nxt = r_state & ~data_in;
    else if (w_sel[SEL_TOG]) w_state_nxt = r_state ^ data_in;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_fsm    <= IDLE;
      r_state  <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_ctrl   <= '0;
      r_period <= '0;
      r_wr_ack <= 1'b0;
      for (int unsigned i = 0; i < NUM_PAT; i++) r_pat[i] <= '0;
    end else begin
      r_fsm    <= w_fsm_nxt;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_wr_ack <= w_valid;
      if (w_sel[SEL_PERIOD]) r_period <= data_in[23:0];
      for (int unsigned i = 0; i < NUM_PAT; i++) begin
        if (w_sel[SEL_PAT0 + i]) r_pat[i] <= data_in;
      end
    end
  end

  assign state    = r_state;
  assign seq_busy = (r_fsm != IDLE);
  assign seq_idx  = r_idx;
  assign wr_ack   = r_wr_ack;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: directed scenarios then random stores,
// checked every cycle against a cycle-budget model of the sequencer.
module tb_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  uop = '0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] state;
  logic        seq_busy;
  logic [1:0]  seq_idx;
  logic        wr_ack;

  gpio_ctrl #(
    .STR_UOP   (5'd9),
    .BASE_ADDR (32'd32),
    .NUM_PAT   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uop      (uop),
    .addr     (addr),
    .data_in  (data_in),
    .state    (state),
    .seq_busy (seq_busy),
    .seq_idx  (seq_idx),
    .wr_ack   (wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] st;
    logic        busy;
    logic [1:0]  idx;
    logic        ack;
    logic        en;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: m_left = WAIT cycles still owed for the current pattern;
  // zero while running means a pattern load is due this cycle.
  logic [31:0] m_state = '0;
  bit          m_run = 0;
  int unsigned m_left = 0;
  logic [1:0]  m_idx = '0;
  bit          m_en = 0;
  bit          m_one = 0;
  logic [23:0] m_per = '0;
  logic [31:0] m_pat [4] = '{default: '0};
  bit          m_ack = 0;

  task automatic model_step(input bit r, input logic [4:0] u, input logic [31:0] a, input logic [31:0] d);
    bit valid;
    int unsigned off;
    bit cpu;
    if (r) begin
      m_state = '0; m_run = 0; m_left = 0; m_idx = '0; m_en = 0; m_one = 0;
      m_per = '0; m_ack = 0;
      for (int i = 0; i < 4; i++) m_pat[i] = '0;
    end else begin
      valid = (u == 5'd9) && (a % 4 == 0) && (a >= 32) && (a <= 68);
      off   = valid ? (a - 32) / 4 : 99;
      cpu   = (off <= 3);
      if (off == 5) begin
        m_en = d[0]; m_one = d[1];
        if (d[0]) begin m_run = 1; m_idx = 0; m_left = 0; end
        else m_run = 0;
      end else if (m_run) begin
        if (m_left == 0) begin
          if (!cpu) begin
            m_state = m_pat[m_idx];
            m_left  = (m_per == 0) ? 1 : m_per;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_idx == 3 && m_one) begin m_run = 0; m_en = 0; end
            else m_idx = m_idx + 2'd1;
          end
        end
      end
      case (off)
        0: m_state = d;
        1: m_state = m_state | d;
        2: m_state = m_state & ~d;
        3: m_state = m_state ^ d;
        4: m_per = d[23:0];
        6, 7, 8, 9: m_pat[off - 6] = d;
        default: ;
      endcase
      m_ack = valid;
    end
  endtask

  task automatic cycle(input bit r, input logic [4:0] u, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    rst = r; uop = u; addr = a; data_in = d;
    model_step(r, u, a, d);
    e.st = m_state; e.busy = m_run; e.idx = m_idx; e.ack = m_ack; e.en = m_en; e.cyc = cyc;
    cyc++;
    q.push_back(e);
  endtask

  task automatic st(input int unsigned off, input logic [31:0] d);
    cycle(0, 5'd9, 32'd32 + off, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state",    e.cyc, state,                  e.st);
        chk("seq_busy", e.cyc, {31'd0, seq_busy},      {31'd0, e.busy});
        chk("seq_idx",  e.cyc, {30'd0, seq_idx},       {30'd0, e.idx});
        chk("wr_ack",   e.cyc, {31'd0, wr_ack},        {31'd0, e.ack});
        chk("ctrl_en",  e.cyc, {31'd0, dut.r_ctrl.en}, {31'd0, e.en});
      end
    end
  end

  initial begin : driver
    int unsigned k, off;
    logic [31:0] a, d;
    logic [4:0]  u;
    bit r;

    // Reset beats a coincident DIRECT store.
    cycle(1, 5'd9, 32'd32, 32'hFFFF_FFFF);
    cycle(1, 5'd9, 32'd32, 32'hFFFF_FFFF);

    st(0, 32'h0000_F0F0);
    st(4, 32'h0F00_0000);
    st(8, 32'h0000_00F0);
    st(12, 32'hFFFF_0000);
    cycle(0, 5'd9, 32'd33, 32'h1234_5678);
    cycle(0, 5'd8, 32'd32, 32'h1234_5678);
    cycle(0, 5'd9, 32'd72, 32'h1234_5678);
    cycle(0, 5'd9, 32'd28 , 32'h1234_5678);
    idle(2);

    st(24, 32'd1); st(28, 32'd2); st(32, 32'd4); st(36, 32'd8);
    st(16, 32'd3); st(20, 32'd1);
    idle(36);

    // DIRECT exactly on the PAT1 load cycle.
    for (int i = 0; i < 50; i++) begin
      if (m_run && m_left == 0 && m_idx == 2'd1) begin
        st(0, 32'hAAAA_5555);
        break;
      end
      idle(1);
    end
    idle(12);

    for (int i = 0; i < 20; i++) begin
      if (m_run && m_left != 0) break;
      idle(1);
    end
    st(20, 32'd0);
    idle(5);

    st(16, 32'd0); st(20, 32'd3);
    idle(14);

    st(16, 32'd5); st(20, 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (m_run && m_left != 0) break;
      idle(1);
    end
    cycle(1, 5'd0, 32'd0, 32'd0);
    idle(3);

    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 199) == 0);
      k = $urandom_range(0, 9);
      if (!r && k < 5) begin
        idle(1);
      end else begin
        off = 4 * $urandom_range(0, 9);
        d   = $urandom;
        if (off == 16) d = $urandom_range(0, 4);
        if (off == 20) d = ($urandom_range(0, 3) == 0) ? 32'd0 : {30'd0, 1'($urandom_range(0, 1)), 1'b1};
        a = 32'd32 + off;
        u = 5'd9;
        if (k == 8) u = 5'($urandom_range(0, 31));
        if (k == 9) a = $urandom_range(0, 80);
        cycle(r, u, a, d);
      end
    end
    idle(2);

    repeat (4) @(negedge clk);
    #3;
    chk("drain", cyc, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Controller in the execute stage that owns the 32-bit GPIO output register and decides what drives it.
- Decodes store micro-ops to a small GPIO control window and applies direct, set, clear and toggle updates.
- Runs an autonomous pattern sequencer that steps through NUM_PAT pattern registers at a programmable period.
- Arbitrates between CPU stores and sequencer steps; CPU stores always win.

Parameters:
- STR_UOP, 5'd9: uop encoding of a store.
- BASE_ADDR, 32'd32: byte address of the control window; must be word-aligned.
- NUM_PAT, 4: number of pattern registers; fixed at 4 in this revision; seq_idx is 2 bits.

Ports:
- clk  in  1  system clock; all registers update on the falling edge, matching the execute-stage store timing.
- rst  in  1  synchronous, active-high reset, sampled on the same edge.
- uop  in  5  current micro-op.
- addr  in  32  store byte address.
- data_in  in  32  store data.
- state  out  32  GPIO output pin state, registered.
- seq_busy  out  1  high while the sequencer FSM is not IDLE.
- seq_idx  out  2  index of the pattern last loaded or next to load.
- wr_ack  out  1  one-cycle pulse for each accepted store in the window.

Behaviour:
- Store qualifier: (uop == STR_UOP) and addr[1:0] == 0 and BASE_ADDR <= addr <= BASE_ADDR+36. Any other uop or address is ignored with no side effects and no wr_ack.
- Address map, byte offsets from BASE_ADDR:
  - +0 DIRECT: state <= data_in
  - +4 SET: state <= state | data_in
  - +8 CLR: state <= state & ~data_in
  - +12 TOG: state <= state ^ data_in
  - +16 PERIOD: 24-bit, data_in[23:0], upper bits ignored
  - +20 CTRL: bit0 EN, bit1 ONESHOT
  - +24/+28/+32/+36: PAT0..PAT3
- Latency: a qualifying store updates its register at the same falling edge it is presented. wr_ack is high during the following cycle.
- Reset values: state=0, seq_busy=0, seq_idx=0, wr_ack=0, PERIOD=0, CTRL=0, PAT0..3=0, FSM=IDLE, cnt=0. Reset overrides any store presented in the same cycle. Reset mid-run returns to IDLE immediately.
- FSM states:
  - IDLE: seq_busy=0. Move to LOAD when a CTRL store sets EN=1; seq_idx <= 0.
  - LOAD: state <= PAT[seq_idx]; cnt <= max(PERIOD,1)-1; go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt==0:
    - if seq_idx==3 and ONESHOT=1: go to IDLE, clear EN, keep state.
    - otherwise: seq_idx <= seq_idx+1 (wraps 3->0), go to LOAD.
- Effective step period is max(PERIOD,1)+1 cycles per pattern (one LOAD cycle plus max(PERIOD,1) WAIT cycles).
- Arbitration, when a DIRECT/SET/CLR/TOG store coincides with LOAD:
  - The CPU update is applied.
  - LOAD stalls in place: no state change from the pattern, seq_idx unchanged, cnt not reloaded. It retries next cycle.
- Stores during WAIT modify state immediately. The sequencer overwrites state at the next LOAD.
- CTRL store with EN=0 in any state: go to IDLE next edge, state retained, seq_idx retained.
- CTRL store with EN=1 while already running: restarts at LOAD with seq_idx=0.
- PERIOD store mid-run takes effect at the next LOAD; the current cnt is not modified.
- PAT store in the same cycle as a LOAD of that index: the LOAD uses the pre-store value; the new value applies on the next visit.
- Only one store per cycle exists, so there are no store-store conflicts.

Decomposition:
- Package gpio_pkg holds:
  - STR_UOP
  - offset localparams: OFF_DIRECT, OFF_SET, OFF_CLR, OFF_TOG, OFF_PERIOD, OFF_CTRL, OFF_PAT0
  - typedef enum logic [1:0] {IDLE, LOAD, WAIT} seq_state_t
  - typedef struct for CTRL: en, oneshot
- One natural sub-module: gpio_decode, a combinational address/uop decoder producing a one-hot register-select vector plus a valid bit. The FSM, counter and state register stay in gpio_ctrl.

Test Plan:
- Reset then idle: assert rst 2 cycles with a store to +0 of 0xFFFFFFFF presented -> state=0, wr_ack=0, seq_busy=0.
- Read-modify ops: DIRECT 0x0000F0F0, SET 0x0F000000, CLR 0x000000F0, TOG 0xFFFF0000 -> state 0x0000F0F0, 0x0F00F0F0, 0x0F00F000, 0xF0FFF000; one wr_ack pulse each. Store to addr 33 or uop 8 -> no change.
- Sequencer loop: PAT0..3 = 1,2,4,8, PERIOD=3, CTRL=1 -> state shows 1,2,4,8,1,... each held 4 cycles; seq_idx tracks 0,1,2,3,0.
- Oneshot and PERIOD 0: PERIOD=0, CTRL=3 -> 1,2,4,8 at 2 cycles each, then IDLE, state=8, CTRL.EN reads 0 internally, seq_busy=0.
- Collision: DIRECT 0xAAAA5555 on the exact LOAD cycle for PAT1 -> state=0xAAAA5555 that cycle; PAT1 appears one cycle later; the subsequent WAIT length is unchanged.
- Mid-run control: CTRL=0 during WAIT -> IDLE next edge, state held. rst asserted during WAIT -> all outputs return to reset values on the next edge.
